// File: rtl/spi_peripheral.sv
// SPI mode-0 slave backed by a byte-wide register file.
// Frame: ADDR_WIDTH address bits, an R/W bit, then DATA_WIDTH data bits; reads drive MISO.
module spi_peripheral #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk_in,
    input  logic                  cs_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic                  miso_oe,
    output logic                  xfer_done,
    output logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  last_rw,
    output logic [DATA_WIDTH-1:0] last_data
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, RLOAD, RSEND, WDATA, WCOMMIT, DONE
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    sclk_d;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   addr_sr;
    logic [DATA_WIDTH-1:0]   data_sr;
    logic [DATA_WIDTH-1:0]   mem [0:(1 << ADDR_WIDTH) - 1];

    logic                    sclk_s;
    logic                    cs_s;
    logic                    mosi_s;
    logic                    sclk_rise;
    logic                    sclk_fall;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    mem_we;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign rd_word   = mem[addr_sr];
    // A raised CS in WCOMMIT is an abort, so it suppresses the write too.
    assign mem_we    = reset_n && (state == WCOMMIT) && !cs_s;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_sr] <= data_sr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            miso_out  <= 1'b0;
            miso_oe   <= 1'b0;
            xfer_done <= 1'b0;
            last_addr <= '0;
            last_rw   <= 1'b0;
            last_data <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            sclk_d    <= sclk_s;
            xfer_done <= 1'b0;

            if (state != IDLE && cs_s) begin
                state   <= IDLE;
                miso_oe <= 1'b0;
                cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!cs_s) begin
                            state <= CMD;
                        end
                    end
                    CMD: begin
                        // The first ADDR_WIDTH rises fill the address; the last one carries R/W.
                        if (sclk_rise) begin
                            if (cnt == CNT_W'(ADDR_WIDTH)) begin
                                cnt   <= '0;
                                state <= mosi_s ? RLOAD : WDATA;
                            end else begin
                                addr_sr <= {addr_sr[ADDR_WIDTH-2:0], mosi_s};
                                cnt     <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    RLOAD: begin
                        data_sr  <= rd_word;
                        miso_out <= rd_word[DATA_WIDTH-1];
                        miso_oe  <= 1'b1;
                        state    <= RSEND;
                    end
                    RSEND: begin
                        if (sclk_rise) begin
                            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                xfer_done <= 1'b1;
                                last_addr <= addr_sr;
                                last_rw   <= 1'b1;
                                last_data <= rd_word;
                                miso_oe   <= 1'b0;
                                state     <= DONE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else if (sclk_fall && cnt != '0) begin
                            data_sr  <= {data_sr[DATA_WIDTH-2:0], 1'b0};
                            miso_out <= data_sr[DATA_WIDTH-2];
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            data_sr <= {data_sr[DATA_WIDTH-2:0], mosi_s};
                            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                cnt   <= '0;
                                state <= WCOMMIT;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    WCOMMIT: begin
                        xfer_done <= 1'b1;
                        last_addr <= addr_sr;
                        last_rw   <= 1'b0;
                        last_data <= data_sr;
                        state     <= DONE;
                    end
                    DONE: begin
                        miso_oe <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        miso_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a bit-banged SPI master plus a register-file
// model and a per-cycle monitor of the commit outputs.
module tb_spi_peripheral;

    localparam int H = 6;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } commit_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sclk_in;
    logic       cs_in;
    logic       mosi_in;
    logic       miso_out;
    logic       miso_oe;
    logic       xfer_done;
    logic [6:0] last_addr;
    logic       last_rw;
    logic [7:0] last_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [0:127];
    commit_t    pending [$];
    logic [6:0] m_addr = '0;
    logic       m_rw   = 1'b0;
    logic [7:0] m_data = '0;
    logic       oe_allowed = 1'b0;
    logic       rst_q = 1'b0;

    spi_peripheral dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk_in   (sclk_in),
        .cs_in     (cs_in),
        .mosi_in   (mosi_in),
        .miso_out  (miso_out),
        .miso_oe   (miso_oe),
        .xfer_done (xfer_done),
        .last_addr (last_addr),
        .last_rw   (last_rw),
        .last_data (last_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_q <= reset_n;

    // Monitor: commits must match the queued expectations, and last_* must track them.
    always @(negedge clk) begin
        if (!rst_q) begin
            m_addr = '0;
            m_rw   = 1'b0;
            m_data = '0;
            pending.delete();
        end else if (xfer_done === 1'b1) begin
            check("xfer_done_expected", 32'(pending.size() > 0), 32'd1);
            if (pending.size() > 0) begin
                m_addr = pending[0].addr;
                m_rw   = pending[0].rw;
                m_data = pending[0].data;
                void'(pending.pop_front());
            end
        end
        check("mon_last_addr", 32'(last_addr), 32'(m_addr));
        check("mon_last_rw",   32'(last_rw),   32'(m_rw));
        check("mon_last_data", 32'(last_data), 32'(m_data));
        if (!oe_allowed) check("mon_miso_oe_idle", 32'(miso_oe), 32'd0);
    end

    task automatic spi_frame(input int nbits, input logic [23:0] tx, input int rst_at,
                             output logic [7:0] rx, output int oe_bad);
        logic is_read;
        rx      = '0;
        oe_bad  = 0;
        is_read = tx[nbits-8];
        @(negedge clk);
        cs_in = 1'b0;
        repeat (2*H) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi_in = tx[nbits-1-i];
            repeat (H) @(negedge clk);
            if (i >= 8 && i < 16) begin
                rx = {rx[6:0], miso_out};
                if (miso_oe !== 1'b1) oe_bad++;
            end
            sclk_in = 1'b1;
            if (i == 7 && is_read) oe_allowed = 1'b1;
            if (i == rst_at) begin
                repeat (2) @(negedge clk);
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                check("reset_miso_oe", 32'(miso_oe), 32'd0);
                check("reset_xfer_done", 32'(xfer_done), 32'd0);
                oe_allowed = 1'b0;
                repeat (H-3) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            sclk_in = 1'b0;
            if (i == 15) oe_allowed = 1'b0;
        end
        mosi_in = 1'b0;
        repeat (H) @(negedge clk);
        cs_in = 1'b1;
        oe_allowed = 1'b0;
        repeat (2*H) @(negedge clk);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] rx;
        int         oe_bad;
        commit_t    c;
        c.addr = a; c.rw = 1'b0; c.data = d;
        pending.push_back(c);
        model_mem[a] = d;
        spi_frame(16, {8'h00, a, 1'b0, d}, -1, rx, oe_bad);
        check("write_commit_seen", 32'(pending.size()), 32'd0);
    endtask

    task automatic do_read(input logic [6:0] a, output logic [7:0] d);
        int      oe_bad;
        commit_t c;
        c.addr = a; c.rw = 1'b1; c.data = model_mem[a];
        pending.push_back(c);
        spi_frame(16, {8'h00, a, 1'b1, 8'h00}, -1, d, oe_bad);
        check("read_oe_during_data", 32'(oe_bad), 32'd0);
        check("read_data_model", 32'(d), 32'(model_mem[a]));
        check("read_commit_seen", 32'(pending.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int         oe_bad;
        commit_t    c;
        reset_n = 1'b0;
        cs_in   = 1'b1;
        sclk_in = 1'b0;
        mosi_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso_out",  32'(miso_out),  32'd0);
        check("rst_miso_oe",   32'(miso_oe),   32'd0);
        check("rst_xfer_done", 32'(xfer_done), 32'd0);
        check("rst_last_addr", 32'(last_addr), 32'd0);
        check("rst_last_rw",   32'(last_rw),   32'd0);
        check("rst_last_data", 32'(last_data), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        do_write(7'h12, 8'h5A);
        check("w12_last_addr", 32'(last_addr), 32'h12);
        check("w12_last_rw",   32'(last_rw),   32'h0);
        check("w12_last_data", 32'(last_data), 32'h5A);

        do_read(7'h12, d);
        check("r12_data",      32'(d),         32'h5A);
        check("r12_last_rw",   32'(last_rw),   32'h1);
        check("r12_last_data", 32'(last_data), 32'h5A);

        do_write(7'h7F, 8'hFF);
        do_write(7'h00, 8'h00);
        do_read(7'h7F, d);
        check("r7f_data", 32'(d), 32'hFF);
        do_read(7'h00, d);
        check("r00_data", 32'(d), 32'h00);

        do_write(7'h03, 8'hA5);
        spi_frame(12, {12'h000, 8'h06, 4'hC}, -1, d, oe_bad);
        check("abort_no_commit", 32'(pending.size()), 32'd0);
        check("abort_last_addr", 32'(last_addr), 32'h03);
        check("abort_last_rw",   32'(last_rw),   32'h0);
        check("abort_last_data", 32'(last_data), 32'hA5);
        do_read(7'h03, d);
        check("r03_after_abort", 32'(d), 32'hA5);

        spi_frame(16, {8'h00, 7'h7F, 1'b1, 8'h00}, 11, d, oe_bad);
        check("rstmid_last_addr", 32'(last_addr), 32'h00);
        check("rstmid_last_data", 32'(last_data), 32'h00);
        do_read(7'h7F, d);
        check("r7f_after_reset", 32'(d), 32'hFF);

        c.addr = 7'h40; c.rw = 1'b0; c.data = 8'h81;
        pending.push_back(c);
        model_mem[7'h40] = 8'h81;
        spi_frame(24, {7'h40, 1'b0, 8'h81, 8'hFF}, -1, d, oe_bad);
        check("long_commit_seen", 32'(pending.size()), 32'd0);
        check("long_last_data",   32'(last_data), 32'h81);
        do_read(7'h40, d);
        check("r40_data", 32'(d), 32'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
